// File: rtl/demux2_wb_unit.sv
// demux2_wb_unit
//   Write-back demultiplexer. Each accepted word is steered by sel into one
//   of three destinations, or it is discarded:
//     00 -> result register (valid/ready handshake toward downstream)
//     01 -> register a
//     10 -> register b
//     11 -> discard, and set the sticky err flag
//   Every accepted word increments an 8-bit wrapping write counter.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   init       synchronous re-initialise, same state effect as rst
//   din        write-back data word
//   din_valid  din/sel valid this cycle
//   sel        destination select
//   din_ready  unit can accept din this cycle (combinational)
//   a_out      register a contents;  a_valid  register a written since reset/init
//   b_out      register b contents;  b_valid  register b written since reset/init
//   res_out    result register;      res_valid  result holds an unconsumed word
//   res_ready  downstream consumes res_out when res_valid is high
//   err        sticky: a discarded (sel=11) word was accepted
//   wr_count   accepted-word count, modulo 256

module demux2_wb_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [1:0]       sel,
    output logic             din_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             a_valid,
    output logic             b_valid,
    output logic [WIDTH-1:0] res_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             err,
    output logic [7:0]       wr_count
);

    localparam logic [1:0] SEL_RES  = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_DROP = 2'b11;

    localparam logic [WIDTH-1:0] A_RESET = {{(WIDTH-1){1'b0}}, 1'b1};

    logic accept;
    logic consume;
    logic res_load;

    // Only a result-bound word can be back-pressured: it would overwrite an
    // unconsumed result. Words for a, b or discard are always accepted.
    // init blocks acceptance so a word offered during re-initialisation is
    // refused rather than silently wiped by the reset of state.
    assign din_ready = !init && !((sel == SEL_RES) && res_valid && !res_ready);
    assign accept    = din_valid && din_ready;
    assign consume   = res_valid && res_ready;
    assign res_load  = accept && (sel == SEL_RES);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            a_out     <= A_RESET;
            b_out     <= '0;
            res_out   <= '0;
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            wr_count  <= 8'd0;
        end else begin
            if (accept) begin
                wr_count <= wr_count + 8'd1;
                case (sel)
                    SEL_A: begin
                        a_out   <= din;
                        a_valid <= 1'b1;
                    end
                    SEL_B: begin
                        b_out   <= din;
                        b_valid <= 1'b1;
                    end
                    SEL_DROP: begin
                        err <= 1'b1;
                    end
                    default: begin
                        res_out <= din;
                    end
                endcase
            end

            // A load in the same cycle as a consume keeps res_valid high
            // (zero-bubble); a consume alone empties the register.
            if (res_load) begin
                res_valid <= 1'b1;
            end else if (consume) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux2_wb_unit.sv
module tb_demux2_wb_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic [W-1:0] din;
    logic         din_valid;
    logic [1:0]   sel;
    logic         din_ready;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic         a_valid;
    logic         b_valid;
    logic [W-1:0] res_out;
    logic         res_valid;
    logic         res_ready;
    logic         err;
    logic [7:0]   wr_count;

    int checks = 0;
    int errors = 0;

    // Reference state, updated from the behavioural rules.
    int m_a, m_b, m_res, m_cnt;
    bit m_av, m_bv, m_rv, m_err;

    demux2_wb_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .din       (din),
        .din_valid (din_valid),
        .sel       (sel),
        .din_ready (din_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .res_out   (res_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err       (err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 1; m_b = 0; m_res = 0; m_cnt = 0;
        m_av = 0; m_bv = 0; m_rv = 0; m_err = 0;
    endtask

    function automatic bit model_ready(input bit i_init, input int i_sel, input bit i_rdy);
        // Refuse while re-initialising, or when a result word would overwrite
        // an unconsumed result that is not being taken this cycle.
        return !i_init && !(i_sel == 0 && m_rv && !i_rdy);
    endfunction

    task automatic compare_outputs();
        check("a_out",     int'(a_out),     m_a);
        check("b_out",     int'(b_out),     m_b);
        check("a_valid",   int'(a_valid),   int'(m_av));
        check("b_valid",   int'(b_valid),   int'(m_bv));
        check("res_out",   int'(res_out),   m_res);
        check("res_valid", int'(res_valid), int'(m_rv));
        check("err",       int'(err),       int'(m_err));
        check("wr_count",  int'(wr_count),  m_cnt);
    endtask

    // One cycle: called at a falling edge. Drives inputs, checks the
    // combinational ready, advances the model, then checks registered outputs
    // at the following falling edge.
    task automatic step(input bit i_rst, input bit i_init, input int i_din,
                        input bit i_valid, input int i_sel, input bit i_rdy);
        bit rdy_exp;
        bit acc;
        rst       = i_rst;
        init      = i_init;
        din       = W'(i_din);
        din_valid = i_valid;
        sel       = 2'(i_sel);
        res_ready = i_rdy;
        #1;
        rdy_exp = model_ready(i_init, i_sel, i_rdy);
        check("din_ready", int'(din_ready), int'(rdy_exp));
        acc = i_valid && rdy_exp;
        if (i_rst || i_init) begin
            model_reset();
        end else begin
            if (acc) begin
                m_cnt = (m_cnt + 1) % 256;
                if (i_sel == 1) begin m_a = i_din % (1 << W); m_av = 1; end
                else if (i_sel == 2) begin m_b = i_din % (1 << W); m_bv = 1; end
                else if (i_sel == 3) m_err = 1;
                else begin m_res = i_din % (1 << W); m_rv = 1; end
            end
            if (m_rv && i_rdy && !(acc && i_sel == 0)) m_rv = 0;
        end
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        rst = 1; init = 0; din = '0; din_valid = 0; sel = 2'b00; res_ready = 0;
        model_reset();
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        check("rst_a_out", int'(a_out), 1);
        check("rst_wr_count", int'(wr_count), 0);

        // Writes to a then b
        step(0, 0, 4'b1010, 1, 1, 0);
        step(0, 0, 4'b0110, 1, 2, 0);
        check("ab_a_out", int'(a_out), 4'b1010);
        check("ab_b_out", int'(b_out), 4'b0110);
        check("ab_count", int'(wr_count), 2);

        // Result back-pressure and zero-bubble replace
        step(0, 0, 4'b0011, 1, 0, 0);
        step(0, 0, 4'b0101, 1, 0, 0);
        check("bp_res_held", int'(res_out), 4'b0011);
        step(0, 0, 4'b0101, 1, 0, 1);
        check("zb_res_out", int'(res_out), 4'b0101);
        check("zb_res_valid", int'(res_valid), 1);
        // Consume alone empties the result, value held
        step(0, 0, 0, 0, 0, 1);
        check("cons_res_valid", int'(res_valid), 0);
        check("cons_res_out", int'(res_out), 4'b0101);

        // Discard sets sticky err until init
        step(0, 0, 4'b1111, 1, 3, 0);
        check("drop_err", int'(err), 1);
        check("drop_count", int'(wr_count), 5);
        step(0, 0, 4'b1001, 1, 2, 0);
        check("err_sticky", int'(err), 1);
        step(0, 1, 4'b1100, 1, 1, 0);
        check("init_err", int'(err), 0);
        check("init_a_out", int'(a_out), 1);

        // Counter wrap after 256 accepts from reset
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 0, $urandom_range(15), 1, $urandom_range(1, 3), 0);
        check("wrap_count", int'(wr_count), 0);
        // Reset wins over a pending accept
        step(1, 0, 4'b1110, 1, 1, 0);
        check("rst_acc_a_out", int'(a_out), 1);
        check("rst_acc_a_valid", int'(a_valid), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 2),
                 int'($urandom_range(15)), ($urandom_range(99) < 75),
                 int'($urandom_range(3)), ($urandom_range(99) < 50));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
